// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin front end for the combinational tiny16 alu.
// One transaction in flight at a time; operands are registered onto the alu,
// held for an opcode-dependent number of cycles, then the result is captured
// and returned to the owning port as a one-cycle strobe.
module alu_arbiter #(
  parameter int WIDTH         = 16,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_opcode,
  input  logic             req0_ar_flag,
  input  logic [WIDTH-1:0] req0_src1,
  input  logic [WIDTH-1:0] req0_src2,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_opcode,
  input  logic             req1_ar_flag,
  input  logic [WIDTH-1:0] req1_src1,
  input  logic [WIDTH-1:0] req1_src2,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_dst,
  output logic [3:0]       rsp_flags,
  output logic [3:0]       alu_opcode,
  output logic             alu_ar_flag,
  output logic [WIDTH-1:0] alu_src1,
  output logic [WIDTH-1:0] alu_src2,
  input  logic [WIDTH-1:0] alu_dst,
  input  logic [3:0]       alu_flags,
  output logic [3:0]       flags_q,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  // cnt holds (hold - 1); mul/div hold for MULDIV_CYCLES, everything else 1
  localparam logic [3:0] MULDIV_M1 = 4'(MULDIV_CYCLES - 1);
  localparam logic [3:0] OP_MUL    = 4'b0101;
  localparam logic [3:0] OP_DIV    = 4'b0110;

  state_t           state;
  logic [3:0]       cnt;
  logic             last_grant;
  logic             owner;

  logic             any_req;
  logic             gnt1;
  logic [3:0]       sel_opcode;
  logic             sel_ar_flag;
  logic [WIDTH-1:0] sel_src1;
  logic [WIDTH-1:0] sel_src2;
  logic [3:0]       sel_cnt;

  // Round-robin pick and payload mux; ready is only offered in IDLE and is
  // forced low while reset is asserted even if a requester is holding valid.
  always_comb begin
    any_req     = req0_valid | req1_valid;
    gnt1        = req1_valid & (~req0_valid | ~last_grant);
    sel_opcode  = gnt1 ? req1_opcode  : req0_opcode;
    sel_ar_flag = gnt1 ? req1_ar_flag : req0_ar_flag;
    sel_src1    = gnt1 ? req1_src1    : req0_src1;
    sel_src2    = gnt1 ? req1_src2    : req0_src2;
    sel_cnt     = (sel_opcode == OP_MUL || sel_opcode == OP_DIV) ? MULDIV_M1 : 4'd0;
    req0_ready  = rst_n & (state == IDLE) & req0_valid & ~gnt1;
    req1_ready  = rst_n & (state == IDLE) & gnt1;
  end

  assign busy = (state != IDLE);

  // Sequencer: accept -> hold operands on the alu -> capture -> strobe owner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      alu_opcode  <= 4'd0;
      alu_ar_flag <= 1'b0;
      alu_src1    <= '0;
      alu_src2    <= '0;
      rsp_dst     <= '0;
      rsp_flags   <= 4'd0;
      flags_q     <= 4'd0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            alu_opcode  <= sel_opcode;
            alu_ar_flag <= sel_ar_flag;
            alu_src1    <= sel_src1;
            alu_src2    <= sel_src2;
            owner       <= gnt1;
            last_grant  <= gnt1;
            cnt         <= sel_cnt;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_dst    <= alu_dst;
            rsp_flags  <= alu_flags;
            flags_q    <= alu_flags;
            rsp0_valid <= ~owner;
            rsp1_valid <= owner;
            state      <= DONE;
          end
        end
        DONE: begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural tiny16 alu.
module tb_alu_arbiter;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [3:0]   req0_opcode = '0, req1_opcode = '0;
  logic         req0_ar_flag = 1'b0, req1_ar_flag = 1'b0;
  logic [W-1:0] req0_src1 = '0, req0_src2 = '0, req1_src1 = '0, req1_src2 = '0;
  logic         rsp0_valid, rsp1_valid;
  logic [W-1:0] rsp_dst;
  logic [3:0]   rsp_flags;
  logic [3:0]   alu_opcode;
  logic         alu_ar_flag;
  logic [W-1:0] alu_src1, alu_src2;
  logic [W-1:0] alu_dst;
  logic [3:0]   alu_flags;
  logic [3:0]   flags_q;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [19:0] q0[$];
  logic [19:0] q1[$];
  int          grant_port[$];
  int          grant_cyc[$];

  alu_arbiter #(.WIDTH(W), .MULDIV_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_ar_flag(req0_ar_flag), .req0_src1(req0_src1), .req0_src2(req0_src2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_ar_flag(req1_ar_flag), .req1_src1(req1_src1), .req1_src2(req1_src2),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_dst(rsp_dst), .rsp_flags(rsp_flags),
    .alu_opcode(alu_opcode), .alu_ar_flag(alu_ar_flag),
    .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_dst(alu_dst), .alu_flags(alu_flags),
    .flags_q(flags_q), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural alu: returns {flags, dst}; flags = {zero, neg, carry, ar_flag}
  function automatic logic [19:0] alu_m(logic [3:0] op, logic ar, logic [W-1:0] a, logic [W-1:0] b);
    logic [16:0] r;
    logic [31:0] m;
    m = a * b;
    case (op)
      4'b0011: r = {1'b0, a} + {1'b0, b};
      4'b0100: r = {1'b0, a} - {1'b0, b};
      4'b0101: r = {1'b0, m[15:0]};
      4'b0110: r = (b == '0) ? 17'h0ffff : {1'b0, a / b};
      4'b0111: r = {1'b0, a & b};
      4'b1000: r = {1'b0, a | b};
      4'b1001: r = {1'b0, a ^ b};
      default: r = {1'b0, a};
    endcase
    return {r[15:0] == 16'd0, r[15], r[16], ar, r[15:0]};
  endfunction

  always_comb {alu_flags, alu_dst} = alu_m(alu_opcode, alu_ar_flag, alu_src1, alu_src2);

  // Edge counter and accept log
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n && req0_valid && req0_ready) begin grant_port.push_back(0); grant_cyc.push_back(cyc); end
    if (rst_n && req1_valid && req1_ready) begin grant_port.push_back(1); grant_cyc.push_back(cyc); end
  end

  // Scoreboard consumer: every response strobe is matched against its port queue
  always @(negedge clk) begin
    logic [19:0] e;
    if (rsp0_valid && rsp1_valid) begin
      checks++; errors++;
      $display("FAIL rsp_both: rsp0_valid=1 rsp1_valid=1, required one-hot");
    end
    if (rsp0_valid || rsp1_valid) begin
      checks++;
      if (rsp0_valid ? (q0.size() == 0) : (q1.size() == 0)) begin
        errors++;
        $display("FAIL rsp_unexpected: port %0d strobed with empty scoreboard at cycle %0d", rsp1_valid, cyc);
      end else begin
        e = rsp0_valid ? q0.pop_front() : q1.pop_front();
        if (rsp_dst !== e[15:0] || rsp_flags !== e[19:16] || flags_q !== e[19:16]) begin
          errors++;
          $display("FAIL rsp_data p%0d: dst=%h flags=%h flags_q=%h, required dst=%h flags=%h",
                   rsp1_valid, rsp_dst, rsp_flags, flags_q, e[15:0], e[19:16]);
        end
      end
    end
  end

  // Driver: push expectation, hold valid until accepted; e = accept edge or -1
  task automatic send(input int p, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      output int e);
    logic [19:0] x;
    x = alu_m(op, 1'b0, a, b);
    if (p == 0) begin
      q0.push_back(x);
      req0_opcode = op; req0_ar_flag = 1'b0; req0_src1 = a; req0_src2 = b; req0_valid = 1'b1;
    end else begin
      q1.push_back(x);
      req1_opcode = op; req1_ar_flag = 1'b0; req1_src1 = a; req1_src2 = b; req1_valid = 1'b1;
    end
    e = -1;
    #1;
    for (int i = 0; i < 40; i++) begin
      if ((p == 0) ? req0_ready : req1_ready) begin
        @(posedge clk); #1;
        e = cyc;
        break;
      end
      @(negedge clk);
    end
    if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  // Wait for a port's strobe; c = capture edge or -1, d = rsp_dst seen
  task automatic wait_rsp(input int p, output int c, output logic [W-1:0] d);
    c = -1; d = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((p == 0) ? rsp0_valid : rsp1_valid) begin c = cyc; d = rsp_dst; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    req0_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0 ||
        rsp_dst !== '0 || rsp_flags !== 4'd0 || flags_q !== 4'd0 ||
        alu_opcode !== 4'd0 || alu_ar_flag !== 1'b0 || alu_src1 !== '0 || alu_src2 !== '0) begin
      errors++;
      $display("FAIL reset_state: ready=%b%b rsp=%b%b busy=%b dst=%h flags=%h fq=%h alu=%h/%b/%h/%h, required all 0",
               req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, rsp_dst, rsp_flags, flags_q,
               alu_opcode, alu_ar_flag, alu_src1, alu_src2);
    end
    req0_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_p0;
    int e, c; logic [W-1:0] d;
    send(0, 4'b0011, 16'd10, 16'd5, e);
    checks++;
    if (req0_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL p0_after_accept: ready=%b busy=%b, required ready=0 busy=1", req0_ready, busy);
    end
    wait_rsp(0, c, d);
    checks++;
    if (e < 0 || c - e != 1 || d !== 16'd15) begin
      errors++; $display("FAIL p0_add: accept=%0d rsp=%0d dst=%0d, required latency 1 dst=15", e, c, d);
    end
    checks++;
    if (rsp1_valid !== 1'b0) begin
      errors++; $display("FAIL p0_rsp1_quiet: rsp1_valid=%b, required 0", rsp1_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mul_p1;
    int e, c, nb; logic [W-1:0] d;
    nb = 0; c = -1; d = '0;
    send(1, 4'b0101, 16'd10, 16'd5, e);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (rsp1_valid) begin c = cyc; d = rsp_dst; end
    end
    checks++;
    if (e < 0 || c - e != 4 || d !== 16'd50) begin
      errors++; $display("FAIL p1_mul: latency=%0d dst=%0d, required 4 and 50", c - e, d);
    end
    checks++;
    if (nb != 5) begin
      errors++; $display("FAIL p1_mul_busy: busy cycles=%0d, required 5", nb);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sweep;
    logic [3:0]   ops[5]  = '{4'b0100, 4'b0110, 4'b0111, 4'b1000, 4'b1001};
    logic [W-1:0] exp[5]  = '{16'd5, 16'd2, 16'd0, 16'd15, 16'd15};
    int           hold[5] = '{1, 4, 1, 1, 1};
    int e, c, pe;
    logic [W-1:0] d;
    pe = -1;
    for (int i = 0; i < 5; i++) begin
      send(0, ops[i], 16'd10, 16'd5, e);
      wait_rsp(0, c, d);
      checks++;
      if (e < 0 || c - e != hold[i] || d !== exp[i]) begin
        errors++; $display("FAIL sweep_op%b: latency=%0d dst=%0d, required %0d and %0d", ops[i], c - e, d, hold[i], exp[i]);
      end
      if (i > 0) begin
        checks++;
        if (e - pe != hold[i-1] + 2) begin
          errors++; $display("FAIL sweep_spacing%0d: %0d cycles, required %0d", i, e - pe, hold[i-1] + 2);
        end
      end
      pe = e;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin;
    int ea, eb, c; logic [W-1:0] d;
    rst_n = 1'b0; @(negedge clk);
    grant_port.delete(); grant_cyc.delete();
    req0_opcode = 4'b0011; req0_src1 = 16'd1; req0_src2 = 16'd2; req0_valid = 1'b1;
    req1_opcode = 4'b1001; req1_src1 = 16'h00f0; req1_src2 = 16'h0ff0; req1_valid = 1'b1;
    rst_n = 1'b1;
    fork
      begin send(0, 4'b0011, 16'd1, 16'd2, ea); send(0, 4'b0100, 16'd9, 16'd3, ea); end
      begin send(1, 4'b1001, 16'h00f0, 16'h0ff0, eb); send(1, 4'b0111, 16'h1234, 16'h00ff, eb); end
    join
    wait_rsp(1, c, d);
    repeat (2) @(negedge clk);
    checks++;
    if (grant_port.size() != 4 ||
        grant_port[0] != 0 || grant_port[1] != 1 || grant_port[2] != 0 || grant_port[3] != 1) begin
      errors++; $display("FAIL rr_order: %0d grants %p, required 0,1,0,1", grant_port.size(), grant_port);
    end else begin
      checks++;
      if (grant_cyc[1] - grant_cyc[0] != 3 || grant_cyc[2] - grant_cyc[1] != 3 || grant_cyc[3] - grant_cyc[2] != 3) begin
        errors++; $display("FAIL rr_spacing: accepts at %p, required every 3 cycles", grant_cyc);
      end
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++; $display("FAIL rr_drain: pending %0d/%0d, required 0/0", q0.size(), q1.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_div;
    int e, c, spurious; logic [W-1:0] d;
    spurious = 0;
    send(0, 4'b0110, 16'd10, 16'd5, e);
    // hold the same request again, as a requester still waiting would
    req0_valid = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0 ||
        rsp_dst !== '0 || rsp_flags !== 4'd0 || flags_q !== 4'd0 ||
        alu_opcode !== 4'd0 || alu_src1 !== '0 || alu_src2 !== '0) begin
      errors++;
      $display("FAIL reset_mid_div: ready=%b%b rsp=%b%b busy=%b dst=%h flags=%h fq=%h alu=%h/%h/%h, required all 0",
               req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, rsp_dst, rsp_flags, flags_q,
               alu_opcode, alu_src1, alu_src2);
    end
    @(negedge clk); rst_n = 1'b1;
    e = -1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (rsp0_valid) spurious++;
      if (req0_ready) begin @(posedge clk); #1; e = cyc; break; end
      @(negedge clk);
    end
    req0_valid = 1'b0;
    checks++;
    if (e < 0 || spurious != 0) begin
      errors++; $display("FAIL reset_reaccept: accept=%0d spurious=%0d, required accept and 0 spurious", e, spurious);
    end
    wait_rsp(0, c, d);
    checks++;
    if (c - e != 4 || d !== 16'd2) begin
      errors++; $display("FAIL reset_div_result: latency=%0d dst=%0d, required 4 and 2", c - e, d);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wait_during_exec;
    int e0, e1, bad, c; logic [W-1:0] d;
    bad = 0;
    send(0, 4'b0101, 16'd7, 16'd3, e0);
    fork
      send(1, 4'b0011, 16'd100, 16'd23, e1);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (busy && req1_ready) bad++;
      end
    join
    checks++;
    if (bad != 0 || e0 < 0 || e1 - e0 != 6) begin
      errors++; $display("FAIL p1_wait: ready-while-busy=%0d accept gap=%0d, required 0 and 6", bad, e1 - e0);
    end
    wait_rsp(1, c, d);
    checks++;
    if (c - e1 != 1 || d !== 16'd123) begin
      errors++; $display("FAIL p1_own_result: latency=%0d dst=%0d, required 1 and 123", c - e1, d);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_p0();
    test_mul_p1();
    test_sweep();
    test_round_robin();
    test_reset_mid_div();
    test_wait_during_exec();
    repeat (3) @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++; $display("FAIL final_drain: pending %0d/%0d, required 0/0", q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencer and two-port arbiter in front of the tiny16 combinational `alu`. Two requesters (port 0: instruction execute, port 1: address/auxiliary unit) submit opcode/operand transactions over valid/ready. The block grants one at a time round-robin, holds registered operands on the ALU for an opcode-dependent number of cycles, captures `dst`/`flags`, and returns a one-cycle response to the granted requester. It also keeps the architectural flags register `flags_q`.

## Interface
- `WIDTH`, 16: datapath width; must match `alu`.
- `MULDIV_CYCLES`, 4: EXEC hold cycles for opcodes 4'b0101 (mul) and 4'b0110 (div); legal range 1..15.
- `clk` in 1: single clock; all state changes on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: port 0 request.
- `req0_ready` out 1: port 0 accepted; transfer when `req0_valid & req0_ready` at a rising edge.
- `req0_opcode` in 4, `req0_ar_flag` in 1, `req0_src1` in WIDTH, `req0_src2` in WIDTH: port 0 payload.
- `req1_valid`, `req1_ready`, `req1_opcode`, `req1_ar_flag`, `req1_src1`, `req1_src2`: port 1, same widths and meaning.
- `rsp0_valid` out 1, `rsp1_valid` out 1: one-cycle result strobe to the owning port.
- `rsp_dst` out WIDTH, `rsp_flags` out 4: result shared by both ports; valid while either `rspN_valid` is high.
- `alu_opcode` out 4, `alu_ar_flag` out 1, `alu_src1` out WIDTH, `alu_src2` out WIDTH: to `alu`, driven directly from operand registers.
- `alu_dst` in WIDTH, `alu_flags` in 4: from `alu`.
- `flags_q` out 4: flags of the most recently completed operation.
- `busy` out 1: high in EXEC and DONE.

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE: if any `reqN_valid`, grant one. Only the granted port's `reqN_ready` is high, combinationally. Both ready are low when no request is present.
- Arbitration: if one port is valid, it wins. If both are valid, the port not granted last wins. `last_grant` resets to 1, so port 0 wins the first tie.
- On the accept edge:
  - Latch opcode, ar_flag, src1 and src2 into operand registers.
  - Record the grant in `owner` and `last_grant`.
  - Load `cnt` with hold-1, where hold is `MULDIV_CYCLES` for 0101/0110 and 1 for every other opcode, including opcodes the ALU leaves undefined.
  - Go to EXEC.
- EXEC:
  - Operand registers drive the `alu_*` outputs unchanged.
  - When `cnt`≠0, decrement it each cycle.
  - When `cnt`=0, at the next edge capture `alu_dst` into `rsp_dst` and `alu_flags` into both `rsp_flags` and `flags_q`, then go to DONE.
- DONE: `rsp<owner>_valid`=1 for exactly this cycle; the other strobe stays 0. Next edge: IDLE. Both `reqN_ready` are 0 here.
- Requesters must hold valid and payload stable until ready. The block never drops or reorders an accepted transaction.
- `rsp_dst`, `rsp_flags` and the `alu_*` outputs hold their values through IDLE until the next capture.
- Reset (any time, including mid-EXEC):
  - State goes to IDLE, `cnt`=0, `last_grant`=1, `owner`=0.
  - The in-flight operation is discarded and no response is issued.
  - `req*_ready`, `rsp*_valid`, `busy`, `rsp_dst`, `rsp_flags`, `flags_q` and all `alu_*` outputs reset to 0.

## Timing
- Accept edge E. ALU inputs are valid from E to E+hold.
- Result captured at edge E+hold. `rspN_valid` is high in the cycle between E+hold and E+hold+1.
- Earliest next accept is edge E+hold+2. Throughput is one op per hold+2 cycles: 3 for 1-cycle ops, 6 for mul/div at the default.
- ALU combinational path: operand register → `alu` → result register, one full cycle per hold cycle. Mul/div may be constrained as a `MULDIV_CYCLES`-cycle multicycle path.
- A request arriving during EXEC or DONE waits; ready is low and the request is granted in the next IDLE.
- A request that deasserts in the same cycle it is granted is not legal stimulus.

## Test plan
- Port 0 only, opcode 0011, src1=10, src2=5:
  - `req0_ready` is high one cycle.
  - One cycle later, `rsp0_valid`=1 with `rsp_dst`=15 and `flags_q`=`rsp_flags`.
  - `rsp1_valid` stays 0.
- Port 1 only, opcode 0101, 10*5:
  - `rsp1_valid` rises 4 cycles after the accept edge with `rsp_dst`=50.
  - `busy` is high for 5 cycles.
- Sweep port 0 with 10,5 through 0100→5, 0110→2, 0111→0, 1000→15, 1001→15:
  - Each `rsp_dst` matches.
  - Spacing is 3 cycles, or 6 for div.
- Both ports valid continuously from reset:
  - Grants go 0,1,0,1.
  - Responses alternate `rsp0_valid`/`rsp1_valid` with no gap beyond the throughput above.
- `rst_n` pulsed low during the 2nd EXEC cycle of a div:
  - All outputs go 0 immediately and no `rsp` pulse follows.
  - The request still held valid is re-accepted after release and completes with `rsp_dst`=2.
- Port 1 valid during port 0's EXEC:
  - `req1_ready` stays 0 until IDLE, then goes high.
  - Port 1 completes with its own operands, unaffected by port 0's result.
